sar_seq: RTL and testbench
==========================

SAR_SEQ -- requirements
Module: sar_seq

Interface
REQ-001 SHALL have parameter NSTEP, default 10, SAR resolution in bits (2..16).
REQ-002 SHALL have parameter NCH, default 4, analogue input channel count (1..16).
REQ-003 SHALL have parameter CH_W, default 2, channel index width, equal to clog2(NCH) and at least 1.
REQ-004 SHALL have ports `f100m_clk` (in, 1, clock; rising edge) and `rstb` (in, 1, asynchronous active-low reset), listed first.
REQ-005 SHALL have ports `soc` (in, 1, start-of-scan pulse) and `stop` (in, 1, stop continuous scan after the current channel).
REQ-006 SHALL have ports `ch_mask` (in, NCH, enabled channels), `cont` (in, 1, continuous scan), `avg_log2` (in, 2, average 2^n conversions) and `smp_cyc` (in, 4, sample length minus 1).
REQ-007 SHALL have ports `busy` (out, 1), `res_data` (out, NSTEP), `res_ch` (out, CH_W), `res_valid` (out, 1), `res_ready` (in, 1), `overrun` (out, 1, pulse) and `err` (out, 1, pulse).
REQ-008 SHALL have analogue-side ports `ms_sar_dh`, `ms_sar_dl` and `ms_sar_rdy` (in, 1 each), and `ms_sar_clock` and `ms_sar_sample` (out, 1 each).
REQ-009 SHALL have analogue-side outputs `ms_sar_sw` (NSTEP), `ms_sar_swb` (NSTEP) and `ms_sar_ch` (CH_W, selected channel).

Function
REQ-010 SHALL implement FSM states IDLE, WAIT_RDY, SAMPLE, CONVERT, ACCUM and NEXT.
REQ-011 IDLE: `soc`=1 with `ch_mask`!=0 SHALL capture `ch_mask`, `cont`, `avg_log2` and `smp_cyc`, select the lowest set channel, and go to WAIT_RDY; `soc` with `ch_mask`=0 SHALL be ignored.
REQ-012 WAIT_RDY SHALL hold until `ms_sar_rdy`=1, then go to SAMPLE.
REQ-013 SAMPLE SHALL assert `ms_sar_sample`=1 for exactly `smp_cyc`+1 cycles, then go to CONVERT with `ms_sar_sw` set to MSB=1 and all other bits 0.
REQ-014 CONVERT SHALL last NSTEP cycles; in cycle k it SHALL resolve trial bit NSTEP-1-k: keep 1 if `ms_sar_dh`=1, else clear it, and set the next lower bit (none after bit 0).
REQ-015 Within CONVERT, `ms_sar_dh`=`ms_sar_dl`=1 SHALL pulse `err` for one cycle and resolve the bit as 0; `ms_sar_dh`=`ms_sar_dl`=0 SHALL resolve the bit as 0 with no error.
REQ-016 ACCUM SHALL add the code to an accumulator of NSTEP+3 bits, which cannot overflow.
REQ-017 ACCUM SHALL return to WAIT_RDY until 2^avg_log2 conversions have been accumulated, then go to NEXT.
REQ-018 NEXT SHALL load `res_data` = accumulator >> avg_log2 (truncation) and `res_ch` = the current channel, set `res_valid`, and clear the accumulator.
REQ-019 NEXT SHALL select the next higher set channel in the captured mask, wrapping to the lowest when `cont`=1 and `stop` has not been latched.
REQ-020 NEXT SHALL go to WAIT_RDY if a channel remains; otherwise it SHALL go to IDLE.
REQ-021 `stop` SHALL be latched in any non-IDLE state and take effect at the next NEXT; the latch SHALL clear on entry to IDLE.
REQ-022 `res_valid` SHALL fall on the cycle after `res_valid`=`res_ready`=1; `res_data` and `res_ch` SHALL stay stable while `res_valid`=1 and `res_ready`=0.
REQ-023 A NEXT load while `res_valid`=1 and `res_ready`=0 SHALL overwrite the result and pulse `overrun` for one cycle; the scan never stalls.
REQ-024 A NEXT load in the same cycle as a handshake SHALL load the new result and keep `res_valid`=1, with no `overrun`.
REQ-025 `busy` SHALL be 1 in every state except IDLE; `soc` while busy SHALL be ignored.
REQ-026 `ms_sar_clock` SHALL equal ~`f100m_clk`, and `ms_sar_swb` SHALL equal ~`ms_sar_sw`.
REQ-027 `ms_sar_ch` SHALL be registered and change only on entry to WAIT_RDY.
REQ-028 Single-conversion latency from `soc` to `res_valid`, with `ms_sar_rdy`=1 and avg_log2=0, SHALL be smp_cyc+NSTEP+5 cycles.

Reset
REQ-029 `rstb` low SHALL force, asynchronously at any point mid-operation: FSM=IDLE, `ms_sar_sw`=0, `ms_sar_sample`=0, `ms_sar_ch`=0, `res_data`=0, `res_ch`=0, `res_valid`=0, `busy`=0, `overrun`=0, `err`=0, accumulator=0, stop latch=0.
REQ-030 A conversion in progress at reset SHALL be discarded, with no partial result.

Structure
REQ-031 A shared package sar_pkg SHALL hold the FSM state encoding, the accumulator guard width (3) and the maximum avg_log2 (3).
REQ-032 The design SHALL contain one sub-module, sar_ch_pick: a combinational next-set-bit search over NCH with wrap.

Verification
REQ-033 NSTEP=10; `dh` pattern 1,0,1,0,0,0,0,0,0,1; soc, mask=0001, avg=0, smp=0 -> `res_data`=0x281, `res_ch`=0, `res_valid` 15 cycles after `soc`.
REQ-034 mask=1010, cont=0 -> results on ch1 then ch3, `ms_sar_ch`=1 then 3, then IDLE with `busy`=0.
REQ-035 avg=2, codes 100,101,102,104 -> `res_data`=101.
REQ-036 `res_ready`=0 held across two results -> second result replaces the first, `overrun` high for 1 cycle.
REQ-037 cont=1, mask=0101, `stop` during ch2 conversion -> ch0, ch2 results, then IDLE.
REQ-038 `dh`=`dl`=1 in CONVERT -> `err` pulse; `rstb` low mid-CONVERT -> all outputs at reset values at once, no result.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared definitions for the SAR conversion sequencer: FSM encoding and
// accumulator sizing constants.
package sar_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    SAMPLE   = 3'd2,
    CONVERT  = 3'd3,
    ACCUM    = 3'd4,
    NEXT     = 3'd5
  } sar_state_t;

  // Extra accumulator bits so that 2^AVG_MAX full-scale codes never overflow
  localparam int ACC_GUARD = 3;
  localparam int AVG_MAX   = 3;

endpackage

// File: rtl/sar_ch_pick.sv
// Combinational channel search: lowest set bit of the mask, and the next set
// bit above the current channel, optionally wrapping back to the lowest.
module sar_ch_pick #(
  parameter int NCH  = 4,
  parameter int CH_W = 2
) (
  input  logic [NCH-1:0]  mask,
  input  logic [CH_W-1:0] cur,
  input  logic            wrap,
  output logic [CH_W-1:0] first,
  output logic [CH_W-1:0] nxt,
  output logic            found
);

  logic [CH_W-1:0] nxt_hi;
  logic            hi_found;

  always_comb begin
    first    = '0;
    nxt_hi   = '0;
    hi_found = 1'b0;
    // Scan downwards so the lowest qualifying index is the one left standing
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first = CH_W'(i);
        if (i > int'(cur)) begin
          nxt_hi   = CH_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    found = hi_found | (wrap & (|mask));
    nxt   = hi_found ? nxt_hi : first;
  end

endmodule

// File: rtl/sar_seq.sv
// SAR ADC sequencer: scans enabled channels, runs the successive-approximation
// search against the analogue comparator, averages and hands results out.
module sar_seq
  import sar_pkg::*;
#(
  parameter int NSTEP = 10,
  parameter int NCH   = 4,
  parameter int CH_W  = 2
) (
  input  logic             f100m_clk,
  input  logic             rstb,
  input  logic             soc,
  input  logic             stop,
  input  logic [NCH-1:0]   ch_mask,
  input  logic             cont,
  input  logic [1:0]       avg_log2,
  input  logic [3:0]       smp_cyc,
  output logic             busy,
  output logic [NSTEP-1:0] res_data,
  output logic [CH_W-1:0]  res_ch,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             overrun,
  output logic             err,
  input  logic             ms_sar_dh,
  input  logic             ms_sar_dl,
  input  logic             ms_sar_rdy,
  output logic             ms_sar_clock,
  output logic             ms_sar_sample,
  output logic [NSTEP-1:0] ms_sar_sw,
  output logic [NSTEP-1:0] ms_sar_swb,
  output logic [CH_W-1:0]  ms_sar_ch
);

  localparam int ACC_W = NSTEP + ACC_GUARD;
  localparam int BI_W  = $clog2(NSTEP);
  localparam int CNV_W = AVG_MAX;

  sar_state_t      state;
  logic [NCH-1:0]  mask_q;
  logic            cont_q;
  logic [1:0]      avg_q;
  logic [3:0]      smp_q;
  logic            stop_q;
  logic [CH_W-1:0] cur_ch;
  logic [3:0]      smp_cnt;
  logic [BI_W-1:0] bit_idx;
  logic [CNV_W-1:0] cnv_cnt;
  logic [CNV_W-1:0] cnv_last;
  logic [ACC_W-1:0] acc;
  logic            bit_val;

  logic [NCH-1:0]  pick_mask;
  logic            pick_wrap;
  logic [CH_W-1:0] pick_first;
  logic [CH_W-1:0] pick_next;
  logic            pick_found;

  // Average of 2^n accumulated codes, truncated toward zero
  function automatic logic [NSTEP-1:0] avg_trunc(input logic [ACC_W-1:0] sum,
                                                 input logic [1:0]       n);
    return NSTEP'(sum >> n);
  endfunction

  // In IDLE the live mask picks the first channel; afterwards the captured one
  assign pick_mask    = (state == IDLE) ? ch_mask : mask_q;
  assign pick_wrap    = cont_q & ~stop_q;
  assign cnv_last     = CNV_W'((1 << avg_q) - 1);
  assign bit_val      = ms_sar_dh & ~ms_sar_dl;
  assign ms_sar_clock = ~f100m_clk;
  assign ms_sar_swb   = ~ms_sar_sw;

  sar_ch_pick #(
    .NCH  (NCH),
    .CH_W (CH_W)
  ) u_pick (
    .mask  (pick_mask),
    .cur   (cur_ch),
    .wrap  (pick_wrap),
    .first (pick_first),
    .nxt   (pick_next),
    .found (pick_found)
  );

  always_ff @(posedge f100m_clk or negedge rstb) begin
    if (!rstb) begin
      state         <= IDLE;
      busy          <= 1'b0;
      mask_q        <= '0;
      cont_q        <= 1'b0;
      avg_q         <= '0;
      smp_q         <= '0;
      stop_q        <= 1'b0;
      cur_ch        <= '0;
      smp_cnt       <= '0;
      bit_idx       <= '0;
      cnv_cnt       <= '0;
      acc           <= '0;
      res_data      <= '0;
      res_ch        <= '0;
      res_valid     <= 1'b0;
      overrun       <= 1'b0;
      err           <= 1'b0;
      ms_sar_sample <= 1'b0;
      ms_sar_sw     <= '0;
      ms_sar_ch     <= '0;
    end else begin
      overrun <= 1'b0;
      err     <= 1'b0;
      if (state != IDLE && stop)
        stop_q <= 1'b1;
      if (res_valid && res_ready)
        res_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (soc && (|ch_mask)) begin
            mask_q    <= ch_mask;
            cont_q    <= cont;
            avg_q     <= avg_log2;
            smp_q     <= smp_cyc;
            cur_ch    <= pick_first;
            ms_sar_ch <= pick_first;
            acc       <= '0;
            cnv_cnt   <= '0;
            busy      <= 1'b1;
            state     <= WAIT_RDY;
          end
        end

        WAIT_RDY: begin
          if (ms_sar_rdy) begin
            smp_cnt       <= '0;
            ms_sar_sample <= 1'b1;
            state         <= SAMPLE;
          end
        end

        SAMPLE: begin
          if (smp_cnt == smp_q) begin
            ms_sar_sample <= 1'b0;
            ms_sar_sw     <= {1'b1, {(NSTEP-1){1'b0}}};
            bit_idx       <= BI_W'(NSTEP - 1);
            state         <= CONVERT;
          end else begin
            smp_cnt <= smp_cnt + 1'b1;
          end
        end

        // One trial bit per cycle; a double-high comparator is an error and reads as 0
        CONVERT: begin
          ms_sar_sw[bit_idx] <= bit_val;
          if (ms_sar_dh && ms_sar_dl)
            err <= 1'b1;
          if (bit_idx == '0) begin
            state <= ACCUM;
          end else begin
            ms_sar_sw[bit_idx - 1'b1] <= 1'b1;
            bit_idx                   <= bit_idx - 1'b1;
          end
        end

        ACCUM: begin
          acc <= acc + ACC_W'(ms_sar_sw);
          if (cnv_cnt == cnv_last) begin
            cnv_cnt <= '0;
            state   <= NEXT;
          end else begin
            cnv_cnt <= cnv_cnt + 1'b1;
            state   <= WAIT_RDY;
          end
        end

        // Result load never waits on the consumer; an unread result is replaced
        NEXT: begin
          res_data  <= avg_trunc(acc, avg_q);
          res_ch    <= cur_ch;
          res_valid <= 1'b1;
          overrun   <= res_valid & ~res_ready;
          acc       <= '0;
          if (pick_found) begin
            cur_ch    <= pick_next;
            ms_sar_ch <= pick_next;
            state     <= WAIT_RDY;
          end else begin
            busy   <= 1'b0;
            stop_q <= 1'b0;
            state  <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_seq.sv
// Bench for sar_seq: a comparator model resolves to a per-conversion target
// code, and a queue-based scoreboard predicts channel order and averages.
module tb_sar_seq;

  localparam int NSTEP = 10;
  localparam int NCH   = 4;
  localparam int CH_W  = 2;

  logic             f100m_clk = 1'b0;
  logic             rstb      = 1'b0;
  logic             soc       = 1'b0;
  logic             stop      = 1'b0;
  logic [NCH-1:0]   ch_mask   = '0;
  logic             cont      = 1'b0;
  logic [1:0]       avg_log2  = '0;
  logic [3:0]       smp_cyc   = '0;
  logic             busy;
  logic [NSTEP-1:0] res_data;
  logic [CH_W-1:0]  res_ch;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic             overrun;
  logic             err;
  logic             ms_sar_dh;
  logic             ms_sar_dl;
  logic             ms_sar_rdy = 1'b1;
  logic             ms_sar_clock;
  logic             ms_sar_sample;
  logic [NSTEP-1:0] ms_sar_sw;
  logic [NSTEP-1:0] ms_sar_swb;
  logic [CH_W-1:0]  ms_sar_ch;

  int n_chk = 0;
  int n_fail = 0;
  int samp_cnt = 0;
  int err_cnt = 0;
  int n_res = 0;
  int n_extra = 0;
  int tgt_q[$];
  int conv_ch_q[$];
  int exp_ch_q[$];
  int exp_data_q[$];

  logic [NSTEP-1:0] cur_tgt  = '0;
  logic             err_mode = 1'b0;
  logic             rdy_rand = 1'b0;
  logic             in_samp  = 1'b0;

  // Ideal comparator: trial code at or below the target keeps the bit
  assign ms_sar_dh = err_mode | (ms_sar_sw <= cur_tgt);
  assign ms_sar_dl = err_mode | ~(ms_sar_sw <= cur_tgt);

  sar_seq #(.NSTEP(NSTEP), .NCH(NCH), .CH_W(CH_W)) dut (
    .f100m_clk     (f100m_clk),
    .rstb          (rstb),
    .soc           (soc),
    .stop          (stop),
    .ch_mask       (ch_mask),
    .cont          (cont),
    .avg_log2      (avg_log2),
    .smp_cyc       (smp_cyc),
    .busy          (busy),
    .res_data      (res_data),
    .res_ch        (res_ch),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .overrun       (overrun),
    .err           (err),
    .ms_sar_dh     (ms_sar_dh),
    .ms_sar_dl     (ms_sar_dl),
    .ms_sar_rdy    (ms_sar_rdy),
    .ms_sar_clock  (ms_sar_clock),
    .ms_sar_sample (ms_sar_sample),
    .ms_sar_sw     (ms_sar_sw),
    .ms_sar_swb    (ms_sar_swb),
    .ms_sar_ch     (ms_sar_ch)
  );

  always #5 f100m_clk = ~f100m_clk;

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Negedge monitor: ready jitter, sample/err counting, target hand-off, results
  always @(negedge f100m_clk) begin
    if (rdy_rand) ms_sar_rdy = ($urandom_range(0, 3) != 0);
    else          ms_sar_rdy = 1'b1;
    if (ms_sar_sample) samp_cnt++;
    if (err) err_cnt++;
    if (ms_sar_sample && !in_samp) begin
      in_samp = 1'b1;
      cur_tgt = (tgt_q.size() != 0) ? NSTEP'(tgt_q.pop_front()) : NSTEP'($urandom_range(0, 1023));
      if (conv_ch_q.size() != 0) chk("ms_sar_ch", 32'(ms_sar_ch), conv_ch_q.pop_front());
    end else if (!ms_sar_sample) begin
      in_samp = 1'b0;
    end
    if (rstb && res_valid && res_ready) begin
      n_res++;
      if (exp_data_q.size() == 0) n_extra++;
      else begin
        chk("res_ch", 32'(res_ch), exp_ch_q.pop_front());
        chk("res_data", 32'(res_data), exp_data_q.pop_front());
      end
    end
  end

  function automatic int model_scan(input logic [NCH-1:0] m, input logic [1:0] a);
    int nc;
    int sum;
    int t;
    nc = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (m[ch]) begin
        sum = 0;
        for (int j = 0; j < (1 << a); j++) begin
          t = int'($urandom_range(0, (1 << NSTEP) - 1));
          tgt_q.push_back(t);
          conv_ch_q.push_back(ch);
          sum += t;
          nc++;
        end
        exp_ch_q.push_back(ch);
        exp_data_q.push_back(sum / (1 << a));
      end
    end
    return nc;
  endfunction

  task automatic clear_model();
    tgt_q.delete();
    conv_ch_q.delete();
    exp_ch_q.delete();
    exp_data_q.delete();
  endtask

  task automatic do_reset();
    @(posedge f100m_clk); #3;
    rstb = 1'b0;
    @(posedge f100m_clk); #1;
    rstb = 1'b1;
    err_mode = 1'b0;
    stop = 1'b0;
    clear_model();
  endtask

  task automatic start(input logic [NCH-1:0] m, input logic c, input logic [1:0] a,
                       input logic [3:0] s);
    @(posedge f100m_clk); #1;
    ch_mask = m; cont = c; avg_log2 = a; smp_cyc = s;
    samp_cnt = 0; err_cnt = 0; n_extra = 0;
    soc = 1'b1;
    @(posedge f100m_clk); #1;
    soc = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (busy && n < maxc) begin
      @(posedge f100m_clk); #1;
      n++;
    end
    chk("idle_timeout", 32'(busy), 0);
    if (busy) do_reset();
  endtask

  task automatic finish_scan(input int smp, input int nconv);
    wait_idle(5000);
    repeat (3) begin @(posedge f100m_clk); #1; end
    chk("smp_len", samp_cnt, (smp + 1) * nconv);
    chk("exp_left", exp_data_q.size(), 0);
    chk("extra_res", n_extra, 0);
  endtask

  initial begin
    int nc, w, bad, seen, t0, t1, base;
    logic [NCH-1:0] m;
    logic [1:0]     a;
    logic [3:0]     s;

    repeat (3) @(posedge f100m_clk);
    #1 rstb = 1'b1;
    @(posedge f100m_clk); #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_data", 32'(res_data), 0);
    chk("rst_res_ch", 32'(res_ch), 0);
    chk("rst_ms_ch", 32'(ms_sar_ch), 0);
    chk("rst_sw", 32'(ms_sar_sw), 0);
    chk("rst_swb", 32'(ms_sar_swb), 32'h3FF);
    chk("rst_sample", 32'(ms_sar_sample), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_err", 32'(err), 0);
    chk("msclk_hi_phase", 32'(ms_sar_clock), 0);
    @(negedge f100m_clk); #1;
    chk("msclk_lo_phase", 32'(ms_sar_clock), 1);

    // Empty mask is ignored
    start('0, 1'b0, 2'd0, 4'd0);
    chk("soc_empty_mask", 32'(busy), 0);

    // Single conversion: code 0x281 on ch0, latency smp+NSTEP+5
    tgt_q.push_back('h281); conv_ch_q.push_back(0);
    exp_ch_q.push_back(0);  exp_data_q.push_back('h281);
    start(4'b0001, 1'b0, 2'd0, 4'd0);
    for (int i = 2; i <= 15; i++) begin
      @(posedge f100m_clk); #1;
      if (i == 14) chk("lat_early", 32'(res_valid), 0);
      if (i == 15) begin
        chk("lat_valid", 32'(res_valid), 1);
        chk("lat_data", 32'(res_data), 'h281);
        chk("lat_ch", 32'(res_ch), 0);
      end
    end
    finish_scan(0, 1);

    // Two channels, one-shot; a soc while busy must not disturb the scan
    nc = model_scan(4'b1010, 2'd0);
    start(4'b1010, 1'b0, 2'd0, 4'd3);
    repeat (5) begin @(posedge f100m_clk); #1; end
    ch_mask = 4'b0001; soc = 1'b1;
    @(posedge f100m_clk); #1;
    soc = 1'b0;
    finish_scan(3, nc);

    // Averaging of four conversions: (100+101+102+104)/4 -> 101
    foreach (tgt_q[i]) tgt_q.delete(i);
    tgt_q.push_back(100); tgt_q.push_back(101); tgt_q.push_back(102); tgt_q.push_back(104);
    repeat (4) conv_ch_q.push_back(0);
    exp_ch_q.push_back(0); exp_data_q.push_back(101);
    start(4'b0001, 1'b0, 2'd2, 4'd1);
    finish_scan(1, 4);

    // Overrun: two results with nobody reading
    t0 = int'($urandom_range(0, 1023));
    t1 = t0 ^ 'h155;
    tgt_q.push_back(t0); tgt_q.push_back(t1);
    conv_ch_q.push_back(0); conv_ch_q.push_back(1);
    exp_ch_q.push_back(1); exp_data_q.push_back(t1);
    res_ready = 1'b0;
    start(4'b0011, 1'b0, 2'd0, 4'd0);
    w = 0;
    while (!res_valid && w < 200) begin @(posedge f100m_clk); #1; w++; end
    chk("ovr_first_valid", 32'(res_valid), 1);
    chk("ovr_first_ch", 32'(res_ch), 0);
    chk("ovr_first_data", 32'(res_data), t0);
    bad = 0; w = 0;
    while (!overrun && w < 200) begin
      @(posedge f100m_clk); #1; w++;
      if (!overrun && (res_data !== NSTEP'(t0) || res_ch !== '0 || !res_valid)) bad++;
    end
    chk("ovr_hold", bad, 0);
    chk("ovr_pulse", 32'(overrun), 1);
    chk("ovr_ch", 32'(res_ch), 1);
    chk("ovr_data", 32'(res_data), t1);
    chk("ovr_valid", 32'(res_valid), 1);
    @(posedge f100m_clk); #1;
    chk("ovr_once", 32'(overrun), 0);
    res_ready = 1'b1;
    finish_scan(0, 2);

    // Continuous scan wraps ch0,ch2,ch0, then stop during ch2 ends it
    for (int k = 0; k < 4; k++) begin
      t0 = int'($urandom_range(0, 1023));
      tgt_q.push_back(t0);
      conv_ch_q.push_back((k % 2) * 2);
      exp_ch_q.push_back((k % 2) * 2);
      exp_data_q.push_back(t0);
    end
    base = n_res;
    start(4'b0101, 1'b1, 2'd0, 4'd2);
    w = 0;
    while (n_res < base + 3 && w < 1000) begin @(posedge f100m_clk); #1; w++; end
    chk("cont_wrap", n_res - base, 3);
    repeat (2) begin @(posedge f100m_clk); #1; end
    stop = 1'b1;
    @(posedge f100m_clk); #1;
    stop = 1'b0;
    finish_scan(2, 4);

    // Comparator reports both high: err each bit, code resolves to 0
    err_mode = 1'b1;
    conv_ch_q.push_back(0);
    exp_ch_q.push_back(0); exp_data_q.push_back(0);
    start(4'b0001, 1'b0, 2'd0, 4'd0);
    finish_scan(0, 1);
    chk("err_cycles", err_cnt, NSTEP);
    err_mode = 1'b0;

    // Randomised one-shot scans with a jittery ready
    rdy_rand = 1'b1;
    for (int k = 0; k < 6; k++) begin
      m = NCH'($urandom_range(1, (1 << NCH) - 1));
      a = 2'($urandom_range(0, 3));
      s = 4'($urandom_range(0, 15));
      nc = model_scan(m, a);
      start(m, 1'b0, a, s);
      finish_scan(int'(s), nc);
    end
    rdy_rand = 1'b0;

    // Asynchronous reset in the middle of a conversion
    conv_ch_q.push_back(2);
    start(4'b0100, 1'b0, 2'd0, 4'd1);
    w = 0;
    while (!ms_sar_sample && w < 100) begin @(posedge f100m_clk); #1; w++; end
    while (ms_sar_sample && w < 100) begin @(posedge f100m_clk); #1; w++; end
    repeat (2) @(posedge f100m_clk);
    #1 chk("pre_rst_busy", 32'(busy), 1);
    #2 rstb = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_valid", 32'(res_valid), 0);
    chk("arst_data", 32'(res_data), 0);
    chk("arst_res_ch", 32'(res_ch), 0);
    chk("arst_ms_ch", 32'(ms_sar_ch), 0);
    chk("arst_sw", 32'(ms_sar_sw), 0);
    chk("arst_sample", 32'(ms_sar_sample), 0);
    chk("arst_overrun", 32'(overrun), 0);
    chk("arst_err", 32'(err), 0);
    @(posedge f100m_clk); #1;
    rstb = 1'b1;
    clear_model();
    seen = 0;
    repeat (40) begin
      @(posedge f100m_clk); #1;
      if (res_valid || busy) seen++;
    end
    chk("no_partial", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
